// File: rtl/imem_loader_pkg.sv
// Constants and state encoding shared by the instruction-memory loader,
// the instruction memory itself and the testbench halt check.
package imem_pkg;

    localparam int          IMEM_ADDR_WIDTH = 8;
    localparam logic [31:0] HALT_WORD       = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// "master" is the loader side, "slave" the byte source / memory side.
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them
// to instruction memory from word 0 until the halt sentinel, holding the CPU meanwhile.
module imem_loader
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter logic [31:0] HALT_WORD  = imem_pkg::HALT_WORD
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    imem_loader_if.master         bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    loader_state_t         state_q;
    loader_state_t         state_d;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           word_buf;
    logic [ADDR_WIDTH:0]   word_count_q;
    logic                  byte_fire;
    logic                  is_halt;
    logic                  last_idx;

    assign byte_fire = (state_q == RECV) && bus.rx_valid;
    assign is_halt   = (word_buf == HALT_WORD);
    assign last_idx  = (word_idx == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RECV;
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                RECV:  if (byte_fire && (byte_cnt == 2'd3)) state_d = WRITE;
                WRITE: begin
                    if (is_halt)       state_d = DONE;
                    else if (last_idx) state_d = ERR;
                    else               state_d = RECV;
                end
                DONE:  state_d = DONE;
                ERR:   state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Byte-lane assembler and word/address counters; start discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt     <= 2'd0;
            word_idx     <= '0;
            word_buf     <= 32'd0;
            word_count_q <= '0;
        end else if (start) begin
            byte_cnt     <= 2'd0;
            word_idx     <= '0;
            word_buf     <= 32'd0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                RECV: begin
                    if (byte_fire) begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
                        byte_cnt                          <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    word_count_q <= word_count_q + 1'b1;
                    if (!is_halt && !last_idx) begin
                        word_idx <= word_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready = (state_q == RECV);
    // The only input-dependent output: a restart landing on the WRITE cycle cancels that write.
    assign bus.we       = (state_q == WRITE) && !start;
    assign bus.waddr    = 32'({word_idx, 2'b00});
    assign bus.wdata    = word_buf;

    assign cpu_hold   = (state_q == RECV) || (state_q == WRITE) || (state_q == ERR);
    assign done       = (state_q == DONE);
    assign overflow   = (state_q == ERR);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a depth-256 instance for the
// main scenarios and a depth-4 instance for the overflow case.
module tb_imem_loader;
    import imem_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       sel;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic       start_m, start_o;
    logic       cur_ready;

    logic       cpu_hold, done, overflow;
    logic [8:0] word_count;
    logic       cpu_hold_o, done_o, overflow_o;
    logic [2:0] word_count_o;

    int checks   = 0;
    int failures = 0;
    int rdy_err  = 0;
    wr_t wlog[$];
    wr_t wlog_o[$];

    imem_loader_if bus ();
    imem_loader_if bus_o ();

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid & ~sel;
    assign bus_o.rx_data  = rx_data;
    assign bus_o.rx_valid = rx_valid & sel;
    assign start_m        = start & ~sel;
    assign start_o        = start & sel;
    assign cur_ready      = sel ? bus_o.rx_ready : bus.rx_ready;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_m),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_ovf (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start_o),
        .bus        (bus_o),
        .cpu_hold   (cpu_hold_o),
        .done       (done_o),
        .overflow   (overflow_o),
        .word_count (word_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.we === 1'b1) wlog.push_back('{bus.waddr, bus.wdata});
        if (bus_o.we === 1'b1) wlog_o.push_back('{bus_o.waddr, bus_o.wdata});
        if (bus.we === 1'b1 && bus.rx_ready === 1'b1) rdy_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte and returns at the negedge right after its handshake.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (cur_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: rx_ready stayed %b, required 1", cur_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready: got %b need 0", bus.rx_ready); end
        checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b need 0", bus.we); end
        checks++; if (bus.waddr !== 32'h0) begin failures++; $display("FAIL rst_waddr: got %h need 0", bus.waddr); end
        checks++; if (bus.wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h need 0", bus.wdata); end
        checks++; if ({cpu_hold, done, overflow} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b need 000", {cpu_hold, done, overflow}); end
        checks++; if (word_count !== 9'd0) begin failures++; $display("FAIL rst_word_count: got %0d need 0", word_count); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL idle_rx_ready: got %b need 0", bus.rx_ready); end

        pulse_start();
        send_byte(8'h5A);
        send_byte(8'hC3);
        checks++; if (bus.wdata !== 32'h0000_C35A) begin failures++; $display("FAIL partial_wdata: got %h need 0000c35a", bus.wdata); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.rx_ready !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL async_rst_ctl: rx_ready=%b cpu_hold=%b need 0 0", bus.rx_ready, cpu_hold); end
        checks++; if (bus.wdata !== 32'h0) begin failures++; $display("FAIL async_rst_wdata: got %h need 0", bus.wdata); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({bus.rx_ready, cpu_hold, done, overflow} !== 4'b0000) begin failures++; $display("FAIL post_rst_idle: got %b need 0000", {bus.rx_ready, cpu_hold, done, overflow}); end

        wlog.delete();
        pulse_start();
        send_word(32'hA1B2_C3D4);
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 32'h0) begin failures++; $display("FAIL rst_reload_write: we=%b waddr=%h need 1 0", bus.we, bus.waddr); end
        @(negedge clk);
        checks++; if (wlog.size() !== 1 || wlog[0].d !== 32'hA1B2_C3D4) begin failures++; $display("FAIL rst_reload_data: writes=%0d need 1 with a1b2c3d4", wlog.size()); end
    endtask

    task automatic test_basic_word();
        pulse_start();
        wlog.delete();
        send_byte(8'h33);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h00);
        checks++; if (bus.we !== 1'b1) begin failures++; $display("FAIL basic_we: got %b need 1", bus.we); end
        checks++; if (bus.waddr !== 32'h0) begin failures++; $display("FAIL basic_waddr: got %h need 0", bus.waddr); end
        checks++; if (bus.wdata !== 32'h0011_0233) begin failures++; $display("FAIL basic_wdata: got %h need 00110233", bus.wdata); end
        checks++; if (bus.rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_write_ctl: rx_ready=%b cpu_hold=%b need 0 1", bus.rx_ready, cpu_hold); end
        @(negedge clk);
        checks++; if (word_count !== 9'd1) begin failures++; $display("FAIL basic_word_count: got %0d need 1", word_count); end
        checks++; if (bus.we !== 1'b0 || bus.rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_after: we=%b rx_ready=%b cpu_hold=%b need 0 1 1", bus.we, bus.rx_ready, cpu_hold); end
        checks++; if (wlog.size() !== 1) begin failures++; $display("FAIL basic_pulses: got %0d need 1", wlog.size()); end
    endtask

    task automatic test_sentinel();
        pulse_start();
        wlog.delete();
        send_word(32'h0000_0093);
        send_word(32'h0010_8113);
        send_word(HALT_WORD);
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 32'h8 || bus.wdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL halt_write: we=%b waddr=%h wdata=%h need 1 8 ffffffff", bus.we, bus.waddr, bus.wdata); end
        checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL halt_early_flags: done=%b cpu_hold=%b need 0 1", done, cpu_hold); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || bus.rx_ready !== 1'b0) begin failures++; $display("FAIL halt_flags: done=%b cpu_hold=%b rx_ready=%b need 1 0 0", done, cpu_hold, bus.rx_ready); end
        checks++; if (word_count !== 9'd3) begin failures++; $display("FAIL halt_word_count: got %0d need 3", word_count); end
        checks++; if (wlog.size() !== 3 || wlog[1].a !== 32'h4 || wlog[1].d !== 32'h0010_8113) begin failures++; $display("FAIL halt_log: writes=%0d need 3 with word1 at 4", wlog.size()); end
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (wlog.size() !== 3 || word_count !== 9'd3 || done !== 1'b1) begin failures++; $display("FAIL done_ignores_bytes: writes=%0d count=%0d done=%b need 3 3 1", wlog.size(), word_count, done); end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [4];
        int gaps [16];
        logic [31:0] w;
        words = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hFFFF_FFFF};
        gaps  = '{0, 1, 0, 0, 2, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0};
        pulse_start();
        wlog.delete();
        rdy_err = 0;
        for (int i = 0; i < 16; i++) begin
            w = words[i / 4];
            repeat (gaps[i]) @(negedge clk);
            send_byte(w[(i % 4) * 8 +: 8]);
        end
        @(negedge clk);
        checks++; if (wlog.size() !== 4) begin failures++; $display("FAIL bp_count: got %0d writes need 4", wlog.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                checks++;
                if (wlog[i].a !== 32'(i * 4) || wlog[i].d !== words[i]) begin
                    failures++;
                    $display("FAIL bp_word%0d: got %h@%h need %h@%h", i, wlog[i].d, wlog[i].a, words[i], 32'(i * 4));
                end
            end
        end
        checks++; if (rdy_err !== 0) begin failures++; $display("FAIL bp_ready_in_write: got %0d cycles need 0", rdy_err); end
        checks++; if (done !== 1'b1 || word_count !== 9'd4) begin failures++; $display("FAIL bp_done: done=%b count=%0d need 1 4", done, word_count); end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        wlog_o.delete();
        pulse_start();
        send_word(32'h0000_0013);
        send_word(32'h0000_0113);
        send_word(32'h0000_0213);
        send_word(32'h0000_0313);
        checks++; if (bus_o.we !== 1'b1 || bus_o.waddr !== 32'hC) begin failures++; $display("FAIL ovf_last_write: we=%b waddr=%h need 1 c", bus_o.we, bus_o.waddr); end
        @(negedge clk);
        checks++; if (overflow_o !== 1'b1 || cpu_hold_o !== 1'b1 || bus_o.rx_ready !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL ovf_flags: ovf=%b hold=%b rdy=%b done=%b need 1 1 0 0", overflow_o, cpu_hold_o, bus_o.rx_ready, done_o); end
        checks++; if (word_count_o !== 3'd4) begin failures++; $display("FAIL ovf_word_count: got %0d need 4", word_count_o); end
        checks++; if (wlog_o.size() !== 4 || wlog_o[2].a !== 32'h8 || wlog_o[3].d !== 32'h0000_0313) begin failures++; $display("FAIL ovf_log: writes=%0d need 4", wlog_o.size()); end
        sel = 1'b0;
    endtask

    task automatic test_restart();
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        pulse_start();
        wlog.delete();
        send_word(32'h1122_3344);
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 32'h0 || bus.wdata !== 32'h1122_3344) begin failures++; $display("FAIL restart_partial: we=%b waddr=%h wdata=%h need 1 0 11223344", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if (word_count !== 9'd1) begin failures++; $display("FAIL restart_partial_count: got %0d need 1", word_count); end

        send_word(32'h5566_7788);
        wlog.delete();
        start = 1'b1;
        #1;
        checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL restart_in_write_we: got %b need 0", bus.we); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (word_count !== 9'd0 || bus.rx_ready !== 1'b1 || wlog.size() !== 0) begin failures++; $display("FAIL restart_in_write_state: count=%0d rdy=%b writes=%0d need 0 1 0", word_count, bus.rx_ready, wlog.size()); end
        send_word(32'h99AA_BBCC);
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 32'h0 || bus.wdata !== 32'h99AA_BBCC) begin failures++; $display("FAIL restart_next_word: we=%b waddr=%h wdata=%h need 1 0 99aabbcc", bus.we, bus.waddr, bus.wdata); end
        @(negedge clk);
        checks++; if (word_count !== 9'd1 || wlog.size() !== 1) begin failures++; $display("FAIL restart_next_count: count=%0d writes=%0d need 1 1", word_count, wlog.size()); end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        test_reset();
        test_basic_word();
        test_sentinel();
        test_backpressure();
        test_overflow();
        test_restart();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
